// File: rtl/phy_cfg_supervisor.sv
// phy_cfg_supervisor
// Drives the MDIO engine's start/read pulses, samples the returned control
// register word, decodes link configuration status and rewrites the
// configuration after RETRY_MAX consecutive bad read-backs.
// Optional feature macro: PHY_CFG_SUP_IRQ_EN adds irq/irq_clr.
module phy_cfg_supervisor #(
    parameter int unsigned POLL_PERIOD = 1000000,
    parameter int unsigned CMD_WAIT    = 48,
    parameter int unsigned PULSE_LEN   = 2,
    parameter int unsigned RETRY_MAX   = 3,
    parameter logic [15:0] EXP_MASK    = 16'h1C00,
    parameter logic [15:0] EXP_VALUE   = 16'h1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] mdio_data,
`ifdef PHY_CFG_SUP_IRQ_EN
    input  logic        irq_clr,
    output logic        irq,
`endif
    output logic        mdio_start,
    output logic        mdio_read,
    output logic        busy,
    output logic        cfg_ok,
    output logic [1:0]  speed,
    output logic        duplex,
    output logic [15:0] reg_value,
    output logic        sample_valid,
    output logic [7:0]  rewrite_cnt
);

    typedef enum logic [2:0] {
        BOOT, IDLE, WR_PULSE, WR_WAIT, RD_PULSE, RD_WAIT, CHECK, POLL_WAIT
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [31:0] fail_reg, fail_next;

    logic        mdio_start_reg;
    logic        mdio_read_reg;
    logic        busy_reg;
    logic        cfg_ok_reg;
    logic [1:0]  speed_reg;
    logic        duplex_reg;
    logic [15:0] reg_value_reg;
    logic        sample_valid_reg;
    logic [7:0]  rewrite_cnt_reg;

    // Per-bit comparison of the read word against the expected configuration;
    // bits outside the mask always compare good.
    logic [15:0] bit_ok;
    logic        match;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_match
            assign bit_ok[gi] = ~EXP_MASK[gi] | (mdio_data[gi] ~^ EXP_VALUE[gi]);
        end
    endgenerate

    assign match = &bit_ok;

    // Next-state logic; the cycle counter restarts on every state change.
    always_comb begin
        state_next = state_reg;
        fail_next  = fail_reg;
        case (state_reg)
            BOOT:      if (cnt_reg == CMD_WAIT - 1) state_next = IDLE;
            IDLE:      if (enable) state_next = WR_PULSE;
            WR_PULSE:  if (cnt_reg == PULSE_LEN - 1) state_next = WR_WAIT;
            WR_WAIT:   if (cnt_reg == CMD_WAIT - PULSE_LEN - 1) state_next = RD_PULSE;
            RD_PULSE:  if (cnt_reg == PULSE_LEN - 1) state_next = RD_WAIT;
            RD_WAIT:   if (cnt_reg == CMD_WAIT - PULSE_LEN - 1) state_next = CHECK;
            CHECK: begin
                if (match) begin
                    fail_next  = '0;
                    state_next = POLL_WAIT;
                end else if (fail_reg == RETRY_MAX - 1) begin
                    fail_next  = '0;
                    state_next = WR_PULSE;
                end else begin
                    fail_next  = fail_reg + 32'd1;
                    state_next = POLL_WAIT;
                end
                // Transaction is complete here, so a dropped enable parks us.
                if (!enable) state_next = IDLE;
            end
            POLL_WAIT: begin
                if (!enable) state_next = IDLE;
                else if (cnt_reg == POLL_PERIOD - 1) state_next = RD_PULSE;
            end
            default:   state_next = BOOT;
        endcase
        cnt_next = (state_next == state_reg) ? cnt_reg + 32'd1 : '0;
    end

    // State, cycle counter and mismatch counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= BOOT;
            cnt_reg   <= '0;
            fail_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            fail_reg  <= fail_next;
        end
    end

    // Registered outputs, derived from the upcoming state so pulses align with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            mdio_start_reg   <= 1'b0;
            mdio_read_reg    <= 1'b0;
            busy_reg         <= 1'b0;
            cfg_ok_reg       <= 1'b0;
            speed_reg        <= 2'b00;
            duplex_reg       <= 1'b0;
            reg_value_reg    <= 16'h0000;
            sample_valid_reg <= 1'b0;
            rewrite_cnt_reg  <= 8'h00;
        end else begin
            mdio_start_reg   <= (state_next == WR_PULSE);
            mdio_read_reg    <= (state_next == RD_PULSE);
            busy_reg         <= (state_next == WR_PULSE) || (state_next == WR_WAIT) ||
                                (state_next == RD_PULSE) || (state_next == RD_WAIT) ||
                                (state_next == CHECK);
            sample_valid_reg <= (state_reg == CHECK);
            if (state_reg == CHECK) begin
                reg_value_reg <= mdio_data;
                speed_reg     <= {mdio_data[6], mdio_data[13]};
                duplex_reg    <= mdio_data[8];
                cfg_ok_reg    <= match;
            end
            if ((state_next == WR_PULSE) && (state_reg != WR_PULSE) &&
                (rewrite_cnt_reg != 8'hFF)) begin
                rewrite_cnt_reg <= rewrite_cnt_reg + 8'd1;
            end
        end
    end

    assign mdio_start   = mdio_start_reg;
    assign mdio_read    = mdio_read_reg;
    assign busy         = busy_reg;
    assign cfg_ok       = cfg_ok_reg;
    assign speed        = speed_reg;
    assign duplex       = duplex_reg;
    assign reg_value    = reg_value_reg;
    assign sample_valid = sample_valid_reg;
    assign rewrite_cnt  = rewrite_cnt_reg;

`ifdef PHY_CFG_SUP_IRQ_EN
    logic irq_reg;

    // Latch a loss of good configuration until acknowledged; a new loss beats the clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_reg <= 1'b0;
        end else if ((state_reg == CHECK) && cfg_ok_reg && !match) begin
            irq_reg <= 1'b1;
        end else if (irq_clr) begin
            irq_reg <= 1'b0;
        end
    end

    assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_phy_cfg_supervisor.sv
// Directed testbench for phy_cfg_supervisor with a short poll period.
// Optional irq checks are built when PHY_CFG_SUP_IRQ_EN is defined.
module tb_phy_cfg_supervisor;

    localparam int CW = 48;
    localparam int PP = 200;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] mdio_data;
    logic        mdio_start;
    logic        mdio_read;
    logic        busy;
    logic        cfg_ok;
    logic [1:0]  speed;
    logic        duplex;
    logic [15:0] reg_value;
    logic        sample_valid;
    logic [7:0]  rewrite_cnt;
`ifdef PHY_CFG_SUP_IRQ_EN
    logic        irq;
    logic        irq_clr;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    phy_cfg_supervisor #(
        .POLL_PERIOD (PP),
        .CMD_WAIT    (CW),
        .PULSE_LEN   (2),
        .RETRY_MAX   (3),
        .EXP_MASK    (16'h1C00),
        .EXP_VALUE   (16'h1000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .mdio_data    (mdio_data),
`ifdef PHY_CFG_SUP_IRQ_EN
        .irq_clr      (irq_clr),
        .irq          (irq),
`endif
        .mdio_start   (mdio_start),
        .mdio_read    (mdio_read),
        .busy         (busy),
        .cfg_ok       (cfg_ok),
        .speed        (speed),
        .duplex       (duplex),
        .reg_value    (reg_value),
        .sample_valid (sample_valid),
        .rewrite_cnt  (rewrite_cnt)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse / sample monitor: rising-edge timestamps, counts, protocol violations.
    int   start_cnt = 0, read_cnt = 0, sample_cnt = 0;
    int   start_rise = -1, read_rise = -1, sample_cyc = -1;
    int   overlap_cnt = 0, gap_viol = 0, last_rise = -100000;
    logic start_q = 1'b0, read_q = 1'b0;

    always @(negedge clock) begin
        start_q <= mdio_start;
        read_q  <= mdio_read;
        if (mdio_start && mdio_read) overlap_cnt <= overlap_cnt + 1;
        if ((mdio_start && !start_q) || (mdio_read && !read_q)) begin
            if (cyc - last_rise < CW) gap_viol <= gap_viol + 1;
            last_rise <= cyc;
        end
        if (mdio_start && !start_q) begin
            start_cnt  <= start_cnt + 1;
            start_rise <= cyc;
        end
        if (mdio_read && !read_q) begin
            read_cnt  <= read_cnt + 1;
            read_rise <= cyc;
        end
        if (sample_valid) begin
            sample_cnt <= sample_cnt + 1;
            sample_cyc <= cyc;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // sel: 0 = start rise, 1 = read rise, 2 = sample strobe
    task automatic wait_evt(input int sel, input int budget, input string tag);
        int n0;
        int n;
        bit seen;
        n0 = (sel == 0) ? start_cnt : (sel == 1) ? read_cnt : sample_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            n = (sel == 0) ? start_cnt : (sel == 1) ? read_cnt : sample_cnt;
            seen = (n != n0);
        end
        tests++;
        assert (seen) else begin
            fails++;
            $error("FAIL %s: observed no event expected one within %0d cycles", tag, budget);
        end
    endtask

    int r0, prev_read, n_start, n_read, en_cyc;

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        mdio_data = 16'h1140;
`ifdef PHY_CFG_SUP_IRQ_EN
        irq_clr   = 1'b0;
`endif
        repeat (3) tick();
        check("rst_ctrl", {mdio_start, mdio_read, busy, cfg_ok, speed, duplex, sample_valid}, 0);
        check("rst_reg_value", reg_value, 16'h0000);
        check("rst_rewrite_cnt", rewrite_cnt, 8'h00);
`ifdef PHY_CFG_SUP_IRQ_EN
        check("rst_irq", irq, 0);
`endif

        // First start pulse after BOOT, then read, then sample.
        reset = 1'b0;
        r0 = cyc;
        wait_evt(0, 200, "first_start_wait");
        check("first_start_cyc", start_rise, r0 + CW + 1);
        check("first_start_busy", busy, 1);
        check("first_start_rwcnt", rewrite_cnt, 8'd1);
        wait_evt(1, 200, "first_read_wait");
        check("first_read_cyc", read_rise, start_rise + CW);
        wait_evt(2, 200, "first_sample_wait");
        check("first_sample_cyc", sample_cyc, read_rise + CW + 1);
        check("first_cfg_ok", cfg_ok, 1);
        check("first_duplex", duplex, 1);
        check("first_speed", speed, 2'b10);
        check("first_reg_value", reg_value, 16'h1140);
        check("first_rwcnt", rewrite_cnt, 8'd1);
        check("first_busy_poll", busy, 0);

        // Polling with good data: spacing PP+CW+1, no extra writes.
        for (int k = 0; k < 2; k++) begin
            prev_read = read_rise;
            wait_evt(1, 600, "poll_read_wait");
            check("poll_read_spacing", read_rise, prev_read + PP + CW + 1);
            wait_evt(2, 200, "poll_sample_wait");
            check("poll_cfg_ok", cfg_ok, 1);
        end
        check("poll_start_cnt", start_cnt, 1);

        // Power-down bit set: three bad checks trigger a rewrite.
        mdio_data = 16'h1940;
        wait_evt(2, 600, "bad1_wait");
        check("bad1_cfg_ok", cfg_ok, 0);
        check("bad1_reg_value", reg_value, 16'h1940);
`ifdef PHY_CFG_SUP_IRQ_EN
        check("bad1_irq_set", irq, 1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("bad1_irq_clr", irq, 0);
`endif
        wait_evt(2, 600, "bad2_wait");
        check("bad2_cfg_ok", cfg_ok, 0);
        check("bad2_start_cnt", start_cnt, 1);
`ifdef PHY_CFG_SUP_IRQ_EN
        check("bad2_irq_stays_clear", irq, 0);
`endif
        wait_evt(2, 600, "bad3_wait");
        check("bad3_start_cnt", start_cnt, 2);
        check("bad3_start_cyc", start_rise, sample_cyc);
        check("bad3_rwcnt", rewrite_cnt, 8'd2);
        mdio_data = 16'h1140;
        wait_evt(1, 200, "rewrite_read_wait");
        check("rewrite_read_cyc", read_rise, start_rise + CW);
        wait_evt(2, 200, "restore_wait");
        check("restore_cfg_ok", cfg_ok, 1);
        check("restore_rwcnt", rewrite_cnt, 8'd2);

`ifdef PHY_CFG_SUP_IRQ_EN
        // Clear requested in the same cycle as a fresh loss: the set wins.
        mdio_data = 16'h1940;
        wait_evt(1, 600, "coinc_read_wait");
        while (cyc < read_rise + CW) tick();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("coinc_sample_now", sample_valid, 1);
        check("coinc_irq", irq, 1);
        mdio_data = 16'h1140;
        wait_evt(2, 600, "coinc_restore_wait");
        check("coinc_restore_cfg_ok", cfg_ok, 1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
`endif

        // Reset during RD_WAIT aborts; BOOT delays the next pulse.
        wait_evt(1, 600, "rst_mid_read_wait");
        repeat (10) tick();
        n_read = read_cnt;
        reset = 1'b1;
        tick();
        check("midrst_ctrl", {mdio_start, mdio_read, busy, cfg_ok, speed, duplex, sample_valid}, 0);
        check("midrst_reg_value", reg_value, 16'h0000);
        check("midrst_rwcnt", rewrite_cnt, 8'h00);
        tick();
        reset = 1'b0;
        r0 = cyc;
        wait_evt(0, 200, "midrst_start_wait");
        check("midrst_start_cyc", start_rise, r0 + CW + 1);
        check("midrst_no_read", read_cnt, n_read);

        // Enable dropped during WR_WAIT: the read still completes, then IDLE.
        repeat (10) tick();
        enable = 1'b0;
        wait_evt(1, 200, "endrop_read_wait");
        check("endrop_read_cyc", read_rise, start_rise + CW);
        wait_evt(2, 200, "endrop_sample_wait");
        check("endrop_cfg_ok", cfg_ok, 1);
        check("endrop_busy", busy, 0);
        n_start = start_cnt;
        n_read  = read_cnt;
        repeat (300) tick();
        check("idle_no_start", start_cnt, n_start);
        check("idle_no_read", read_cnt, n_read);
        check("idle_busy", busy, 0);
        check("idle_cfg_ok_hold", cfg_ok, 1);
        enable = 1'b1;
        en_cyc = cyc;
        wait_evt(0, 50, "reenable_start_wait");
        check("reenable_start_cyc", start_rise, en_cyc + 1);
        check("reenable_rwcnt", rewrite_cnt, 8'd2);

        check("no_overlap", overlap_cnt, 0);
        check("no_short_gap", gap_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
